// File: rtl/wb_regfile.sv
// Writeback stage: result select, 32x32 register file with WB->ID bypass,
// retired-instruction counter and a sticky illegal-select flag.
module wb_regfile #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned NREGS = 32,
   parameter int unsigned CNT_W = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             RegWrite_MEM,
   input  logic [1:0]       ResultSrc_MEM,
   input  logic [XLEN-1:0]  ALUresult_MEM,
   input  logic [XLEN-1:0]  MemReadData_MEM,
   input  logic [XLEN-1:0]  PC_next_MEM,
   input  logic [4:0]       rd_EXMEM_MEM,
   input  logic             valid_MEM,
   input  logic [4:0]       rs1_ID,
   input  logic [4:0]       rs2_ID,
   output logic [XLEN-1:0]  rd1_ID,
   output logic [XLEN-1:0]  rd2_ID,
   output logic [XLEN-1:0]  Result_WB,
   output logic [CNT_W-1:0] instret,
   output logic             wb_err
);

   // x0 has no storage; entries 1..NREGS-1 are real flops
   logic [XLEN-1:0] regs [1:NREGS-1];
   logic            we;
   logic            illegal;

   always_comb begin
      unique case (ResultSrc_MEM)
         2'b00:   Result_WB = ALUresult_MEM;
         2'b01:   Result_WB = MemReadData_MEM;
         2'b10:   Result_WB = PC_next_MEM;
         default: Result_WB = '0;
      endcase
   end

   assign illegal = valid_MEM & RegWrite_MEM & (ResultSrc_MEM == 2'b11);
   assign we      = RegWrite_MEM & valid_MEM & (rd_EXMEM_MEM != 5'd0)
                    & (ResultSrc_MEM != 2'b11);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int unsigned i = 1; i < NREGS; i++) regs[i] <= '0;
         instret <= '0;
         wb_err  <= 1'b0;
      end else begin
         for (int unsigned i = 1; i < NREGS; i++) begin
            if (we && rd_EXMEM_MEM == 5'(i)) regs[i] <= Result_WB;
         end
         if (valid_MEM) instret <= instret + CNT_W'(1);
         if (illegal)   wb_err  <= 1'b1;
      end
   end

   // Reads are forced to zero during reset so the bypass path cannot leak data
   always_comb begin
      rd1_ID = '0;
      if (rst && rs1_ID != 5'd0) begin
         if (we && rs1_ID == rd_EXMEM_MEM) begin
            rd1_ID = Result_WB;
         end else begin
            for (int unsigned i = 1; i < NREGS; i++) begin
               if (rs1_ID == 5'(i)) rd1_ID = regs[i];
            end
         end
      end
   end

   always_comb begin
      rd2_ID = '0;
      if (rst && rs2_ID != 5'd0) begin
         if (we && rs2_ID == rd_EXMEM_MEM) begin
            rd2_ID = Result_WB;
         end else begin
            for (int unsigned i = 1; i < NREGS; i++) begin
               if (rs2_ID == 5'(i)) rd2_ID = regs[i];
            end
         end
      end
   end

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile; a second instance with a 4-bit counter
// exercises instret wrap-around.
module tb_wb_regfile;

   logic        clk = 1'b0;
   logic        rst;
   logic        RegWrite_MEM;
   logic [1:0]  ResultSrc_MEM;
   logic [31:0] ALUresult_MEM;
   logic [31:0] MemReadData_MEM;
   logic [31:0] PC_next_MEM;
   logic [4:0]  rd_EXMEM_MEM;
   logic        valid_MEM;
   logic [4:0]  rs1_ID;
   logic [4:0]  rs2_ID;
   logic [31:0] rd1_ID, rd2_ID, Result_WB;
   logic [63:0] instret;
   logic        wb_err;

   logic [31:0] s_rd1, s_rd2, s_res;
   logic [3:0]  s_instret;
   logic        s_err;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   wb_regfile #(.XLEN(32), .NREGS(32), .CNT_W(64)) dut (
      .clk(clk), .rst(rst), .RegWrite_MEM(RegWrite_MEM), .ResultSrc_MEM(ResultSrc_MEM),
      .ALUresult_MEM(ALUresult_MEM), .MemReadData_MEM(MemReadData_MEM),
      .PC_next_MEM(PC_next_MEM), .rd_EXMEM_MEM(rd_EXMEM_MEM), .valid_MEM(valid_MEM),
      .rs1_ID(rs1_ID), .rs2_ID(rs2_ID), .rd1_ID(rd1_ID), .rd2_ID(rd2_ID),
      .Result_WB(Result_WB), .instret(instret), .wb_err(wb_err)
   );

   wb_regfile #(.XLEN(32), .NREGS(32), .CNT_W(4)) dut_small (
      .clk(clk), .rst(rst), .RegWrite_MEM(RegWrite_MEM), .ResultSrc_MEM(ResultSrc_MEM),
      .ALUresult_MEM(ALUresult_MEM), .MemReadData_MEM(MemReadData_MEM),
      .PC_next_MEM(PC_next_MEM), .rd_EXMEM_MEM(rd_EXMEM_MEM), .valid_MEM(valid_MEM),
      .rs1_ID(rs1_ID), .rs2_ID(rs2_ID), .rd1_ID(s_rd1), .rd2_ID(s_rd2),
      .Result_WB(s_res), .instret(s_instret), .wb_err(s_err)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic v, input logic rw, input logic [1:0] src,
                        input logic [31:0] alu, input logic [31:0] mem,
                        input logic [31:0] pc, input logic [4:0] rd);
      valid_MEM = v; RegWrite_MEM = rw; ResultSrc_MEM = src;
      ALUresult_MEM = alu; MemReadData_MEM = mem; PC_next_MEM = pc; rd_EXMEM_MEM = rd;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b0;
      rs1_ID = 5'd5; rs2_ID = 5'd0;
      drive(1'b0, 1'b0, 2'b00, '0, '0, '0, 5'd0);
      check("reset_rd1", 64'(rd1_ID), 64'h0);
      check("reset_instret", instret, 64'h0);
      check("reset_err", 64'(wb_err), 64'h0);
      @(negedge clk);
      rst = 1'b1;

      // Fill x5, then pulse reset mid-cycle
      drive(1'b1, 1'b1, 2'b00, 32'h1234, 32'h0, 32'h0, 5'd5);
      tick();
      drive(1'b0, 1'b0, 2'b00, '0, '0, '0, 5'd0);
      check("x5_written", 64'(rd1_ID), 64'h1234);
      check("instret_one", instret, 64'd1);
      #1 rst = 1'b0;
      #1;
      check("async_rd1", 64'(rd1_ID), 64'h0);
      check("async_instret", instret, 64'h0);
      check("async_err", 64'(wb_err), 64'h0);
      rst = 1'b1;

      // Load data select and write to x7
      rs2_ID = 5'd7;
      drive(1'b1, 1'b1, 2'b01, 32'h11, 32'hDEADBEEF, 32'h22, 5'd7);
      check("sel_load", 64'(Result_WB), 64'hDEADBEEF);
      tick();
      drive(1'b0, 1'b0, 2'b00, '0, '0, '0, 5'd0);
      check("x7_read", 64'(rd2_ID), 64'hDEADBEEF);
      check("instret_x7", instret, 64'd1);

      // Bypass on both ports over an older x3 value
      drive(1'b1, 1'b1, 2'b00, 32'hAAAA, 32'h0, 32'h0, 5'd3);
      tick();
      rs1_ID = 5'd3; rs2_ID = 5'd3;
      drive(1'b1, 1'b1, 2'b10, 32'h5, 32'h6, 32'h104, 5'd3);
      check("bypass_rd1", 64'(rd1_ID), 64'h104);
      check("bypass_rd2", 64'(rd2_ID), 64'h104);
      check("sel_pc", 64'(Result_WB), 64'h104);
      tick();
      drive(1'b0, 1'b0, 2'b00, '0, '0, '0, 5'd0);
      check("x3_committed", 64'(rd1_ID), 64'h104);
      check("instret_x3", instret, 64'd3);

      // x0 protection
      rs1_ID = 5'd0;
      drive(1'b1, 1'b1, 2'b00, 32'hFFFFFFFF, 32'h0, 32'h0, 5'd0);
      check("x0_before", 64'(rd1_ID), 64'h0);
      check("sel_alu", 64'(Result_WB), 64'hFFFFFFFF);
      tick();
      drive(1'b0, 1'b0, 2'b00, '0, '0, '0, 5'd0);
      check("x0_after", 64'(rd1_ID), 64'h0);
      check("instret_x0", instret, 64'd4);
      check("x0_err", 64'(wb_err), 64'h0);

      // Illegal select inside a bubble must be ignored
      drive(1'b0, 1'b1, 2'b11, 32'h1, 32'h2, 32'h3, 5'd9);
      tick();
      check("bubble_illegal_err", 64'(wb_err), 64'h0);
      check("bubble_illegal_cnt", instret, 64'd4);

      // Illegal select on a real instruction
      rs1_ID = 5'd9;
      drive(1'b1, 1'b1, 2'b00, 32'h99, 32'h0, 32'h0, 5'd9);
      tick();
      drive(1'b1, 1'b1, 2'b11, 32'h55, 32'h66, 32'h77, 5'd9);
      check("illegal_result", 64'(Result_WB), 64'h0);
      check("illegal_no_bypass", 64'(rd1_ID), 64'h99);
      tick();
      drive(1'b0, 1'b0, 2'b00, '0, '0, '0, 5'd0);
      check("illegal_x9", 64'(rd1_ID), 64'h99);
      check("illegal_err", 64'(wb_err), 64'h1);
      check("illegal_cnt", instret, 64'd6);
      for (int i = 0; i < 10; i++) begin
         drive(1'b1, 1'b1, 2'b00, 32'(i), 32'h0, 32'h0, 5'd10);
         tick();
      end
      rs1_ID = 5'd10;
      drive(1'b0, 1'b0, 2'b00, '0, '0, '0, 5'd0);
      check("err_sticky", 64'(wb_err), 64'h1);
      check("x10_last", 64'(rd1_ID), 64'h9);
      check("instret_16", instret, 64'd16);

      // Bubbles with RegWrite asserted
      for (int i = 0; i < 5; i++) begin
         drive(1'b0, 1'b1, 2'b00, 32'hBAD, 32'hBAD, 32'hBAD, 5'd10);
         check("bubble_no_bypass", 64'(rd1_ID), 64'h9);
         tick();
      end
      check("bubble_x10", 64'(rd1_ID), 64'h9);
      check("bubble_cnt", instret, 64'd16);

      // Counter wrap on the 4-bit instance
      drive(1'b0, 1'b0, 2'b00, '0, '0, '0, 5'd0);
      #1 rst = 1'b0;
      #1 rst = 1'b1;
      check("small_reset", 64'(s_instret), 64'h0);
      for (int i = 0; i < 17; i++) begin
         drive(1'b1, 1'b0, 2'b00, '0, '0, '0, 5'd0);
         tick();
      end
      drive(1'b0, 1'b0, 2'b00, '0, '0, '0, 5'd0);
      check("small_wrap", 64'(s_instret), 64'd1);
      check("big_17", instret, 64'd17);
      check("small_err", 64'(s_err), 64'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
